// File: rtl/issue_pkg.sv
// Shared definitions for the issue scheduler: default buffer depth, slot index
// width helper and the protocol-error cause encodings.
package issue_pkg;

    localparam int BS_DEFAULT = 16;

    // One-hot so that both causes can be flagged in the same cycle.
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_DUP_FILL = 2'b01;
    localparam logic [1:0] ERR_BAD_DONE = 2'b10;

    function automatic int slot_w(input int bs);
        return (bs > 1) ? $clog2(bs) : 1;
    endfunction

endpackage

// File: rtl/issue_rr_pick.sv
// Combinational find-first-set over a request vector, scanning upward from ptr
// and wrapping from BS-1 back to 0.
module issue_rr_pick
    import issue_pkg::*;
#(
    parameter int BS = BS_DEFAULT,
    localparam int IW = slot_w(BS)
) (
    input  logic [BS-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = 0; i < BS; i++) begin
            // BS is a power of two, so IW-bit addition wraps for free.
            k = ptr + IW'(i);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Issue scheduler: tracks slot occupancy/issued state and offers one ready slot
// per cycle. Define ISSUE_RR_EN for round-robin pick; otherwise lowest index wins.
module issue_select
    import issue_pkg::*;
#(
    parameter int BS = BS_DEFAULT,
    localparam int IW = slot_w(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BS-1:0] independent_instr,
    input  logic          fill_valid,
    input  logic [IW-1:0] fill_idx,
    output logic          issue_valid,
    output logic [IW-1:0] issue_idx,
    input  logic          issue_ready,
    input  logic          done_valid,
    input  logic [IW-1:0] done_idx,
    output logic          free_valid,
    output logic [IW-1:0] free_idx,
    output logic [IW:0]   occ_count,
    output logic          err
);

    // Handshake: issue_idx transfers on an edge where issue_valid && issue_ready;
    // while valid is high and ready is low, valid and idx hold unchanged.

    logic [BS-1:0] occ_q, occ_d;
    logic [BS-1:0] iss_q, iss_d;
    logic          issue_valid_q, issue_valid_d;
    logic [IW-1:0] issue_idx_q, issue_idx_d;
    logic [IW:0]   occ_count_q, occ_count_d;
    logic          err_q, err_d;
    logic [IW-1:0] rr_ptr_q;

`ifdef ISSUE_RR_EN
    logic [IW-1:0] rr_ptr_d;
`else
    assign rr_ptr_q = '0;
`endif

    logic [BS-1:0] cand;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          load, hs, done_held, bad_done, dup_fill;
    logic [1:0]    err_cause;

    assign cand = independent_instr & occ_q & ~iss_q;

    issue_rr_pick #(.BS(BS)) u_pick (
        .req   (cand),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    issue_rr_pick #(.BS(BS)) u_free (
        .req   (~occ_q),
        .ptr   ('0),
        .found (free_valid),
        .idx   (free_idx)
    );

    always_comb begin
        occ_d         = occ_q;
        iss_d         = iss_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        occ_count_d   = '0;
`ifdef ISSUE_RR_EN
        rr_ptr_d      = rr_ptr_q;
`endif

        load      = !issue_valid_q || issue_ready;
        hs        = issue_valid_q && issue_ready;
        done_held = issue_valid_q && !issue_ready && (done_idx == issue_idx_q);
        bad_done  = done_valid && (!iss_q[done_idx] || done_held);

        // Done lands before fill so a same-slot done+fill is a clean recycle.
        if (done_valid && !bad_done) begin
            occ_d[done_idx] = 1'b0;
            iss_d[done_idx] = 1'b0;
        end
        dup_fill = fill_valid && occ_d[fill_idx];

        if (load) begin
            if (pick_found) begin
                issue_valid_d   = 1'b1;
                issue_idx_d     = pick_idx;
                iss_d[pick_idx] = 1'b1;
            end else begin
                issue_valid_d   = 1'b0;
            end
        end

        if (fill_valid) begin
            occ_d[fill_idx] = 1'b1;
            iss_d[fill_idx] = 1'b0;
        end

`ifdef ISSUE_RR_EN
        if (hs) begin
            rr_ptr_d = issue_idx_q + IW'(1);
        end
`endif

        for (int i = 0; i < BS; i++) begin
            occ_count_d = occ_count_d + {{IW{1'b0}}, occ_d[i]};
        end

        err_cause = (dup_fill ? ERR_DUP_FILL : ERR_NONE) | (bad_done ? ERR_BAD_DONE : ERR_NONE);
        err_d     = err_q || (err_cause != ERR_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q         <= '0;
            iss_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            occ_count_q   <= '0;
            err_q         <= 1'b0;
`ifdef ISSUE_RR_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            occ_q         <= occ_d;
            iss_q         <= iss_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            occ_count_q   <= occ_count_d;
            err_q         <= err_d;
`ifdef ISSUE_RR_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    a_err_sticky: assert property (@(posedge clk) disable iff (rst) err_q |=> err_q);

    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign occ_count   = occ_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: table vectors, directed multi-cycle
// sequences and randomized traffic against a slot-level reference model.
module tb_issue_select;
    import issue_pkg::*;

    localparam int BS = BS_DEFAULT;
    localparam int IW = slot_w(BS);

    logic          clk;
    logic          rst;
    logic [BS-1:0] independent_instr;
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic          issue_valid;
    logic [IW-1:0] issue_idx;
    logic          issue_ready;
    logic          done_valid;
    logic [IW-1:0] done_idx;
    logic          free_valid;
    logic [IW-1:0] free_idx;
    logic [IW:0]   occ_count;
    logic          err;

    issue_select #(.BS(BS)) dut (
        .clk               (clk),
        .rst               (rst),
        .independent_instr (independent_instr),
        .fill_valid        (fill_valid),
        .fill_idx          (fill_idx),
        .issue_valid       (issue_valid),
        .issue_idx         (issue_idx),
        .issue_ready       (issue_ready),
        .done_valid        (done_valid),
        .done_idx          (done_idx),
        .free_valid        (free_valid),
        .free_idx          (free_idx),
        .occ_count         (occ_count),
        .err               (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    bit m_occ[BS];
    bit m_iss[BS];
    bit m_v;
    int m_idx;
    int m_rr;
    bit m_err;

    task automatic model_reset();
        for (int j = 0; j < BS; j++) begin
            m_occ[j] = 1'b0;
            m_iss[j] = 1'b0;
        end
        m_v   = 1'b0;
        m_idx = 0;
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int j = 0; j < BS; j++) c += int'(m_occ[j]);
        return c;
    endfunction

    function automatic int m_free();
        for (int j = 0; j < BS; j++) if (!m_occ[j]) return j;
        return -1;
    endfunction

    task automatic model_step(input bit fv, input int fi, input bit dv, input int di,
                              input bit rdy, input logic [BS-1:0] ind);
        bit hs, load, held, bad, dup;
        int pick;
        hs   = m_v && rdy;
        load = !m_v || rdy;
        pick = -1;
        if (load) begin
            for (int k = 0; k < BS; k++) begin
                int j = (m_rr + k) % BS;
                if (pick < 0 && ind[j] && m_occ[j] && !m_iss[j]) pick = j;
            end
        end
        held = m_v && !rdy && (di == m_idx);
        bad  = dv && (!m_iss[di] || held);
        if (dv && !bad) begin
            m_occ[di] = 1'b0;
            m_iss[di] = 1'b0;
        end
        dup = fv && m_occ[fi];
`ifdef ISSUE_RR_EN
        if (hs) m_rr = (m_idx + 1) % BS;
`endif
        if (load) begin
            if (pick >= 0) begin
                m_v          = 1'b1;
                m_idx        = pick;
                m_iss[pick]  = 1'b1;
            end else begin
                m_v = 1'b0;
            end
        end
        if (fv) begin
            m_occ[fi] = 1'b1;
            m_iss[fi] = 1'b0;
        end
        if (bad || dup) m_err = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit fv, input int fi, input bit dv, input int di,
                       input bit rdy, input logic [BS-1:0] ind);
        fill_valid        = fv;
        fill_idx          = IW'(fi);
        done_valid        = dv;
        done_idx          = IW'(di);
        issue_ready       = rdy;
        independent_instr = ind;
        model_step(fv, fi, dv, di, rdy, ind);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input logic [BS-1:0] ind);
        cyc(1'b0, 0, 1'b0, 0, rdy, ind);
    endtask

    task automatic do_reset();
        fill_valid        = 1'b0;
        fill_idx          = '0;
        done_valid        = 1'b0;
        done_idx          = '0;
        issue_ready       = 1'b0;
        independent_instr = '0;
        rst               = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string name);
        int f;
        logic [IW-1:0] got_f, exp_f;
        f     = m_free();
        got_f = (f >= 0) ? free_idx : '0;
        exp_f = (f >= 0) ? IW'(f) : '0;
        check(name,
              32'({issue_valid, issue_idx, occ_count, free_valid, got_f, err}),
              32'({m_v, IW'(m_idx), (IW+1)'(m_count()), (f >= 0), exp_f, m_err}));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            fv;
        int            fi;
        bit            dv;
        int            di;
        bit            rdy;
        logic [BS-1:0] ind;
        bit            ev;
        int            eidx;
        int            ecnt;
        int            efree;
        bit            eerr;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [BS-1:0] ind;
        int fi, di, n;
        bit fv, dv, rdy;
        int pool[$];

        rst = 1'b1;
        fill_valid = 1'b0; fill_idx = '0; done_valid = 1'b0; done_idx = '0;
        issue_ready = 1'b0; independent_instr = '0;
        model_reset();
        #12;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_idx", issue_idx, 0);
        check("rst_free_valid", free_valid, 1);
        check("rst_free_idx", free_idx, 0);
        check("rst_occ_count", occ_count, 0);
        check("rst_err", err, 0);

        // Fill 3 and 5, issue them back to back, then recycle slots.
        vt[0] = '{1, 3, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0};
        vt[1] = '{1, 5, 0, 0, 1, 16'h0028, 1, 3, 2, 0, 0};
        vt[2] = '{0, 0, 0, 0, 1, 16'h0028, 1, 5, 2, 0, 0};
        vt[3] = '{0, 0, 0, 0, 1, 16'h0028, 0, 5, 2, 0, 0};
        vt[4] = '{1, 0, 1, 3, 1, 16'h0000, 0, 5, 2, 1, 0};
        vt[5] = '{1, 1, 1, 5, 1, 16'h0000, 0, 5, 2, 2, 0};
        vt[6] = '{1, 2, 0, 0, 1, 16'h0000, 0, 5, 3, 3, 0};
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].fv, vt[i].fi, vt[i].dv, vt[i].di, vt[i].rdy, vt[i].ind);
            check($sformatf("vec%0d", i),
                  32'({issue_valid, issue_idx, occ_count, free_idx, err}),
                  32'({vt[i].ev, IW'(vt[i].eidx), (IW+1)'(vt[i].ecnt), IW'(vt[i].efree), vt[i].eerr}));
        end

        // Throughput: four ready slots issue on consecutive cycles.
        do_reset();
        for (int s = 0; s < 4; s++) cyc(1, s, 0, 0, 1, '0);
        for (int s = 0; s < 4; s++) exp_q.push_back(IW'(s));
        for (int c = 0; c < 4; c++) begin
            idle(1, 16'h000F);
            check("tput_valid", issue_valid, 1);
            if (exp_q.size() > 0) check("tput_idx", issue_idx, exp_q.pop_front());
        end
        idle(1, 16'h000F);
        check("tput_drain", issue_valid, 0);

        // Backpressure: slot 7 held while independent_instr toggles.
        do_reset();
        cyc(1, 7, 0, 0, 0, '0);
        cyc(1, 8, 0, 0, 0, 16'h0080);
        check("bp_first_valid", issue_valid, 1);
        check("bp_first_idx", issue_idx, 7);
        for (int c = 0; c < 4; c++) begin
            idle(0, BS'($urandom) ^ (c[0] ? 16'h0180 : 16'h0100));
            check("bp_hold", {issue_valid, issue_idx}, {1'b1, IW'(7)});
        end
        idle(1, 16'h0000);
        check("bp_accept_drop", issue_valid, 0);

        // Round-robin versus fixed priority after accepting slot 9.
        do_reset();
        cyc(1, 9, 0, 0, 0, '0);
        cyc(1, 2, 0, 0, 0, 16'h0200);
        cyc(1, 12, 0, 0, 0, 16'h0000);
        check("rr_hold9", {issue_valid, issue_idx}, {1'b1, IW'(9)});
        idle(1, 16'h0000);
        check("rr_accept9", issue_valid, 0);
        idle(1, 16'h1004);
`ifdef ISSUE_RR_EN
        check("rr_pick", {issue_valid, issue_idx}, {1'b1, IW'(12)});
`else
        check("rr_pick", {issue_valid, issue_idx}, {1'b1, IW'(2)});
`endif

        // Same-cycle done+fill on slot 3, then a duplicate fill.
        do_reset();
        cyc(1, 3, 0, 0, 1, '0);
        idle(1, 16'h0008);
        check("sd_issue3", {issue_valid, issue_idx}, {1'b1, IW'(3)});
        idle(1, 16'h0000);
        check("sd_accept3", issue_valid, 0);
        cyc(1, 3, 1, 3, 1, '0);
        check("sd_recycle", {occ_count, err}, {(IW+1)'(1), 1'b0});
        cyc(1, 3, 0, 0, 1, '0);
        check("sd_dup_err", err, 1);
        idle(1, 16'h0008);
        check("sd_unissued", {issue_valid, issue_idx}, {1'b1, IW'(3)});
        idle(1, 16'h0000);
        idle(1, 16'h0000);
        check("sd_err_sticky", err, 1);

        // Done on an unissued slot is ignored and flags err.
        do_reset();
        cyc(1, 4, 0, 0, 1, '0);
        cyc(0, 0, 1, 4, 1, '0);
        check("bad_done_unissued", {occ_count, err}, {(IW+1)'(1), 1'b1});

        // Done on the held, unaccepted slot is ignored and flags err.
        do_reset();
        cyc(1, 6, 0, 0, 0, '0);
        idle(0, 16'h0040);
        cyc(0, 0, 1, 6, 0, 16'h0040);
        check("bad_done_held", {issue_valid, issue_idx, occ_count, err},
              {1'b1, IW'(6), (IW+1)'(1), 1'b1});

        // Asynchronous reset mid-cycle with a pending issue.
        do_reset();
        cyc(1, 6, 0, 0, 0, '0);
        idle(0, 16'h0040);
        check("ar_pending", issue_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_state", {issue_valid, occ_count, free_valid, free_idx, err},
              {1'b0, (IW+1)'(0), 1'b1, IW'(0), 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Random legal traffic: err must stay clear.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            ind = BS'($urandom);
            pool.delete();
            for (int j = 0; j < BS; j++) if (!m_occ[j]) pool.push_back(j);
            fv = (pool.size() > 0) && ($urandom_range(0, 1) == 1);
            fi = fv ? pool[$urandom_range(0, pool.size() - 1)] : 0;
            pool.delete();
            for (int j = 0; j < BS; j++)
                if (m_iss[j] && !(m_v && !rdy && j == m_idx) && j != fi) pool.push_back(j);
            dv = (pool.size() > 0) && ($urandom_range(0, 1) == 1);
            di = dv ? pool[$urandom_range(0, pool.size() - 1)] : 0;
            cyc(fv, fi, dv, di, rdy, ind);
            check_model("rand_legal");
        end

        // Random traffic including protocol violations.
        do_reset();
        n = 0;
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 2) != 0);
            ind = BS'($urandom);
            fv  = ($urandom_range(0, 2) == 0);
            fi  = $urandom_range(0, BS - 1);
            dv  = ($urandom_range(0, 2) == 0);
            di  = (m_v && $urandom_range(0, 1) == 1) ? m_idx : $urandom_range(0, BS - 1);
            cyc(fv, fi, dv, di, rdy, ind);
            check_model("rand_any");
            n++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
